qnigma_fifo_sc_frame: RTL
=========================

Name: qnigma_fifo_sc_frame

Overview:
- Parametrised single-clock FIFO with frame (packet) semantics for the qnigma packet datapath.
- Writer streams words speculatively, then commits or aborts the frame. Readers only ever see committed words.
- Adds fill level, almost-full and almost-empty thresholds, and overflow-drop handling.
- Sits between MAC/parser write side and protocol-engine read side wherever a bad or oversize frame must be discarded without leaking partial data.

Parameters:
- D, 4, address bits; depth = 2**D words.
- W, 16, data width in bits.
- AF_THR, 2**D-2, almost_full asserts when used >= AF_THR; legal range 1..2**D.
- AE_THR, 1, almost_empty asserts when level <= AE_THR; legal range 0..2**D-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- write  in  1  write strobe for data_in.
- data_in  in  W  write data.
- commit  in  1  end of frame; makes all accepted words of the frame readable.
- abort  in  1  discard the open frame.
- read  in  1  read request.
- data_out  out  W  read data, registered.
- valid_out  out  1  one-cycle pulse qualifying data_out.
- full  out  1  used == 2**D.
- empty  out  1  level == 0.
- almost_full  out  1  used >= AF_THR.
- almost_empty  out  1  level <= AE_THR.
- level  out  D+1  committed, readable word count.
- drop  out  1  one-cycle pulse: a frame was dropped because it overflowed.
- drop_cnt  out  16  dropped-frame counter (optional feature).

Behaviour:
- State and pointers:
  - Three (D+1)-bit pointers: wr_ptr (speculative write), cm_ptr (commit), rd_ptr.
  - used = wr_ptr - rd_ptr; level = cm_ptr - rd_ptr; both modulo 2**(D+1).
  - Memory address = pointer[D-1:0].
- Reset (rst_n low at clk edge):
  - All pointers = 0; any open frame is discarded.
  - data_out = 0, valid_out = 0, drop = 0, ovf flag = 0, drop_cnt = 0.
  - Memory contents are not cleared.
  - Outputs after reset: empty = 1, full = 0, level = 0, almost_empty = 1, almost_full = 0 (if AF_THR > 0).
- Flags:
  - full, empty, almost_*, level are combinational from the registered pointers.
  - They update in the cycle after the causing edge.
- Write:
  - Accepted if write && !full && !ovf.
  - On acceptance: mem[wr_ptr] <= data_in; wr_ptr++.
  - write while full sets ovf; every further word of that frame is dropped.
  - No bypass: a write while full is refused even if read is active in the same cycle.
- Commit:
  - commit && !abort && !ovf: cm_ptr <= new wr_ptr, including a word accepted in the same cycle.
  - commit && ovf: treated as abort; drop pulses next cycle; ovf cleared.
- Abort:
  - wr_ptr <= cm_ptr; ovf cleared.
  - A write in the same cycle is discarded.
  - Abort wins over commit.
- Read:
  - read && !empty: data_out <= mem[rd_ptr]; rd_ptr++; valid_out = 1 next cycle.
  - Latency is 1 cycle. Back-to-back reads give one word per cycle.
  - read while empty is ignored: valid_out = 0, data_out holds.
  - Uncommitted words are never readable, even when used > 0.
- Same cycle read + commit: the read uses the pre-commit level. Newly committed words are readable from the next cycle.
- Wrap-around: pointers wrap naturally at 2**(D+1); full and empty stay correct across wrap.
- commit or abort with no open frame and no write: no effect.

Optional Feature:
- Macro QNIGMA_FIFO_STAT_EN.
- Defined:
  - drop_cnt increments on every drop pulse and saturates at 16'hFFFF.
  - drop_cnt is cleared only by reset.
- Undefined:
  - drop_cnt is tied to 0 and no counter logic is synthesised.
  - drop still functions.

Decomposition:
- Package qnigma_fifo_pkg holds:
  - localparam STAT_W = 16 and typedef stat_cnt_t.
  - A function computing the pointer difference modulo 2**(D+1).
- One sub-module: qnigma_ram_sdp, a simple dual-port RAM (one write port, one registered read port, depth 2**D, width W).
- The FIFO control logic stays in the top module.

Test Plan (D=4, W=8, AF_THR=14, AE_THR=1):
- Write 5 words 0x10..0x14 with commit on 0x14, then read 5 -> level 0→5 after commit, valid_out on 5 consecutive cycles with data 0x10..0x14, then empty = 1.
- Write 3 words with no commit, then read -> level = 0, empty = 1, no valid_out. Assert abort -> used = 0, full = 0.
- Write 20 words with commit on the 20th -> full after 16 writes, drop pulses once, level = 0, drop_cnt = 1 with the macro defined and 0 without.
- Commit a 16-word frame, then read + write + commit same cycle -> write refused (full), read returns first word, level = 15, used = 15.
- Run 40 frames of 3 words with interleaved reads so pointers wrap -> data order preserved, no spurious full or empty, almost_empty = 1 when level ≤ 1, almost_full = 1 when used ≥ 14.
- Deassert rst_n mid-frame after committing 4 words and writing 2 more -> next cycle level = 0, empty = 1, valid_out = 0, drop = 0.

Source files
------------

// File: rtl/qnigma_fifo_pkg.sv
// qnigma_fifo_pkg
// Shared types and helpers for the qnigma frame FIFO.
//   STAT_W     : width of the dropped-frame statistics counter
//   stat_cnt_t : statistics counter type
//   ptr_diff() : pointer distance modulo 2**pw
package qnigma_fifo_pkg;

  localparam int STAT_W = 16;

  typedef logic [STAT_W-1:0] stat_cnt_t;

  // Distance a - b on pw-bit wrapping pointers. The caller casts the result
  // back to its own pointer width.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/qnigma_ram_sdp.sv
// qnigma_ram_sdp
// Simple dual-port RAM: one write port, one registered read port.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset, clears only the read register
//   i_we     : write enable
//   i_waddr  : write address (D bits)
//   i_wdata  : write data (W bits)
//   i_re     : read enable; o_rdata updates on the next edge, holds otherwise
//   i_raddr  : read address (D bits)
//   o_rdata  : registered read data (W bits)
// The storage array itself is never reset.
module qnigma_ram_sdp
  import qnigma_fifo_pkg::*;
#(
  parameter int D = 4,
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [D-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_re,
  input  logic [D-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);

  logic [W-1:0] r_mem [2**D];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/qnigma_fifo_sc_frame.sv
// qnigma_fifo_sc_frame
// Single-clock FIFO with frame semantics. Words are written speculatively
// and only become readable once the frame is committed; an aborted or
// overflowed frame is rewound without leaking any of its words.
//   clk, rst_n     : clock, synchronous active-low reset
//   write, data_in : write strobe and data
//   commit, abort  : close the open frame (abort wins over commit)
//   read           : read request
//   data_out       : registered read data, qualified by valid_out
//   full, empty    : used == 2**D, level == 0
//   almost_full    : used >= AF_THR
//   almost_empty   : level <= AE_THR
//   level          : committed, readable word count
//   drop           : one-cycle pulse when an overflowed frame is discarded
//   drop_cnt       : saturating dropped-frame counter
// Optional feature macro: QNIGMA_FIFO_STAT_EN enables drop_cnt; without it
// drop_cnt reads 0 and no counter is built.
module qnigma_fifo_sc_frame
  import qnigma_fifo_pkg::*;
#(
  parameter int D      = 4,
  parameter int W      = 16,
  parameter int AF_THR = 2**D - 2,
  parameter int AE_THR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         write,
  input  logic [W-1:0] data_in,
  input  logic         commit,
  input  logic         abort,
  input  logic         read,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [D:0]   level,
  output logic         drop,
  output logic [15:0]  drop_cnt
);

  localparam logic [D:0] DEPTH_L = {1'b1, {D{1'b0}}};
  localparam logic [D:0] AF_L    = (D+1)'(AF_THR);
  localparam logic [D:0] AE_L    = (D+1)'(AE_THR);

  logic [D:0] r_wr_ptr;
  logic [D:0] r_cm_ptr;
  logic [D:0] r_rd_ptr;
  logic       r_ovf;
  logic       r_valid;
  logic       r_drop;

  logic [D:0] w_used;
  logic [D:0] w_level;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_ovf_hit;
  logic       w_frame_bad;
  logic       w_drop_now;
  logic [D:0] w_wr_next;

  assign w_used  = (D+1)'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), D+1));
  assign w_level = (D+1)'(ptr_diff(32'(r_cm_ptr), 32'(r_rd_ptr), D+1));

  assign full         = (w_used == DEPTH_L);
  assign empty        = (w_level == '0);
  assign almost_full  = (w_used >= AF_L);
  assign almost_empty = (w_level <= AE_L);
  assign level        = w_level;

  // A write during abort is discarded, so it never advances wr_ptr.
  assign w_wr_acc  = write && !full && !r_ovf && !abort;
  assign w_rd_acc  = read && !empty;
  assign w_wr_next = r_wr_ptr + (D+1)'(w_wr_acc);

  // A word refused for lack of space corrupts the frame even when the commit
  // arrives in the same cycle, so the frame counts as overflowed right away.
  assign w_ovf_hit   = write && full && !r_ovf;
  assign w_frame_bad = r_ovf || w_ovf_hit;
  assign w_drop_now  = commit && !abort && w_frame_bad;

  qnigma_ram_sdp #(
    .D (D),
    .W (W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[D-1:0]),
    .i_wdata (data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[D-1:0]),
    .o_rdata (data_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      r_drop  <= w_drop_now;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (abort || w_drop_now) begin
        // Rewind the open frame to the last commit point.
        r_wr_ptr <= r_cm_ptr;
        r_ovf    <= 1'b0;
      end else if (commit) begin
        r_wr_ptr <= w_wr_next;
        r_cm_ptr <= w_wr_next;
      end else begin
        r_wr_ptr <= w_wr_next;
        if (w_ovf_hit) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign valid_out = r_valid;
  assign drop      = r_drop;

`ifdef QNIGMA_FIFO_STAT_EN
  function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  stat_cnt_t r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop_now) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule
